demo_dout_capture: RTL and testbench
====================================

// Module: demo_dout_capture
// PURPOSE
//  Downstream stage of the demo accumulator. Watches its 8-bit dout bus every clock.
//  Each time the value changes, it records a {new value, delta} event in a small FIFO.
//  The FIFO drains over a valid/ready interface, so a slower consumer (scoreboard,
//  UART bridge) can see every accumulator update. Overruns are flagged, never hidden.
// PARAMETERS
//  WIDTH  8  width of the monitored bus and of each stored field
//  DEPTH  4  FIFO entries; power of two, >= 2
// PORTS
//  clk        in   1             clock, all logic on posedge
//  reset      in   1             reset, synchronous, active-high
//  dout_in    in   WIDTH         monitored accumulator output
//  out_valid  out  1             FIFO head holds an event
//  out_ready  in   1             consumer accepts head this cycle
//  out_data   out  WIDTH         event: new value of dout_in
//  out_delta  out  WIDTH         event: new - previous, modulo 2**WIDTH
//  count      out  $clog2(DEPTH)+1  entries currently held
//  overflow   out  1             sticky: an event was dropped
// BEHAVIOUR
//  - Reset (sync, wins over everything):
//    - prev <= 0; FIFO pointers and count <= 0; overflow <= 0.
//    - Outputs next cycle: out_valid=0, count=0; out_data/out_delta don't-care while !out_valid.
//  - Event detect: push = !reset && (dout_in != prev). prev <= dout_in every non-reset cycle.
//    - Entry = {dout_in, dout_in - prev}. Subtraction is WIDTH bits, wraps (e.g. 0x02-0xFE=0x04).
//  - Pop = out_valid && out_ready. Head is show-ahead from storage; out_valid = (count!=0).
//  - Latency: change sampled at edge N -> out_valid=1 with that entry after edge N (cycle N+1).
//  - Ordering: strict FIFO; pointers wrap modulo DEPTH.
//  - Handshake: while out_valid && !out_ready, out_data/out_delta/out_valid are held stable.
//  - Boundaries:
//    - Full, push, no pop: entry dropped, count stays DEPTH, overflow <= 1.
//    - Full, push and pop same cycle: both happen, count stays DEPTH, no overflow.
//    - Empty, pop requested: ignored (out_valid=0).
//    - Empty, push: entry visible next cycle. Push and pop never bypass the FIFO.
//    - overflow clears only on reset.
//    - Reset mid-stream: all pending entries discarded. The first post-reset change is
//      measured against prev=0.
// CONFIGURATION
//  DEMO_CAPTURE_FORMAL_EN defined: the module contains concurrent assert properties,
//  checked on every non-reset cycle:
//   - count <= DEPTH.
//   - out_valid == (count != 0).
//   - Head stable while stalled: $past(out_valid && !out_ready) -> $stable(out_data, out_delta).
//   - overflow, once set, remains set until reset.
//   - count changes by exactly +push_accepted -pop.
//  Plus an initial assume(reset), so sby prove mode starts from reset.
//  Not defined: no formal constructs at all; pure synthesizable RTL, same ports/behaviour.
// TESTING
//  1. Reset 2 cycles, dout_in held 0 -> out_valid=0, count=0, overflow=0.
//  2. dout_in 0->0x05 at edge 3, out_ready=1 -> cycle 4: out_valid=1, data=0x05, delta=0x05; popped, count back to 0.
//  3. out_ready=0; dout_in 0x01,0x02,0x03,0x04,0x05 on successive edges (DEPTH=4)
//     -> count=4, overflow=1. Then drain: 0x01/0x01, 0x02/0x01, 0x03/0x01, 0x04/0x01.
//  4. Full FIFO, out_ready=1, new change same cycle -> count stays 4, overflow unchanged, order kept.
//  5. Wrap: prev=0xFE, dout_in=0x02 -> data=0x02, delta=0x04.
//  6. Reset asserted with 3 entries queued -> next cycle count=0, out_valid=0. Then dout_in=0x07
//     -> data=0x07, delta=0x07.

Source files
------------

// File: rtl/demo_dout_capture.sv
// demo_dout_capture: watches the accumulator's dout bus and records every change
// as a {new value, delta} event in a small show-ahead FIFO. The FIFO drains over
// a valid/ready interface. Dropped events set a sticky overflow flag.
//
// Optional build macro: DEMO_CAPTURE_FORMAL_EN adds concurrent assertions and an
// initial reset assumption for formal proof. When the macro is undefined the module
// contains only synthesizable logic, with the same ports and behaviour.
module demo_dout_capture #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           dout_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [WIDTH-1:0]           out_delta,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] mem_data_r  [DEPTH];
  logic [WIDTH-1:0] mem_delta_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             overflow_r;

  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             push_acc_s;
  logic             drop_s;
  logic [WIDTH-1:0] delta_s;
  logic [CW-1:0]    count_next_s;

  // Event detection, handshake decode and the next occupancy value.
  always_comb begin
    push_s       = (dout_in != prev_r);
    delta_s      = dout_in - prev_r;
    pop_s        = (count_r != {CW{1'b0}}) && out_ready;
    full_s       = (count_r == CW'(DEPTH));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_acc_s   = push_s && (!full_s || pop_s);
    drop_s       = push_s && full_s && !pop_s;
    count_next_s = count_r;
    if (push_acc_s && !pop_s) begin
      count_next_s = count_r + CW'(1);
    end else if (pop_s && !push_acc_s) begin
      count_next_s = count_r - CW'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Pointer, occupancy, previous-value and sticky overflow state.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_r     <= {WIDTH{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      prev_r  <= dout_in;
      count_r <= count_next_s;
      if (push_acc_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Event storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (!reset && push_acc_s) begin
      mem_data_r[wr_ptr_r]  <= dout_in;
      mem_delta_r[wr_ptr_r] <= delta_s;
    end
  end

  // Show-ahead head and status outputs, all taken straight from registers.
  always_comb begin
    out_valid = (count_r != {CW{1'b0}});
    out_data  = mem_data_r[rd_ptr_r];
    out_delta = mem_delta_r[rd_ptr_r];
    count     = count_r;
    overflow  = overflow_r;
  end

`ifdef DEMO_CAPTURE_FORMAL_EN
  // Formal runs start from a reset cycle.
  initial assume (reset);

  // Bound on occupancy.
  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    count_r <= CW'(DEPTH));

  // Valid mirrors occupancy.
  a_valid_count: assert property (@(posedge clk) disable iff (reset)
    out_valid == (count_r != {CW{1'b0}}));

  // Head held while the consumer stalls.
  a_head_stable: assert property (@(posedge clk) disable iff (reset)
    (!$past(reset) && $past(out_valid && !out_ready)) |->
      ($stable(out_data) && $stable(out_delta)));

  // Overflow is sticky until reset.
  a_overflow_sticky: assert property (@(posedge clk) disable iff (reset)
    (!$past(reset) && $past(overflow_r)) |-> overflow_r);

  // Occupancy moves by exactly accepted pushes minus pops.
  a_count_step: assert property (@(posedge clk) disable iff (reset)
    !$past(reset) |->
      (count_r == ($past(count_r) + CW'($past(push_acc_s)) - CW'($past(pop_s)))));
`else
`endif

endmodule

// File: tb/tb_demo_dout_capture.sv
// Scoreboard bench for demo_dout_capture: the stimulus thread pushes hand-computed
// {data, delta} events; a negedge monitor pops and compares on every handshake.
module tb_demo_dout_capture;

  logic       clk;
  logic       reset;
  logic [7:0] dout_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] out_delta;
  logic [2:0] count;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q [$];

  demo_dout_capture #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .dout_in   (dout_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_delta (out_delta),
    .count     (count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input logic [7:0] d, input logic [7:0] dl);
    exp_q.push_back({d, dl});
  endtask

  // Monitor: compares each consumed head and checks stability during stalls.
  logic       stall_r = 1'b0;
  logic [7:0] stall_data;
  logic [7:0] stall_delta;
  always @(negedge clk) begin
    if (reset) begin
      stall_r = 1'b0;
    end else begin
      if (stall_r) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_data", int'(out_data), int'(stall_data));
        check("stall_delta", int'(out_delta), int'(stall_delta));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event actual=0x%0h/0x%0h required=none", out_data, out_delta);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check("ev_data", int'(out_data), int'(e[15:8]));
          check("ev_delta", int'(out_delta), int'(e[7:0]));
        end
      end
      stall_r     = out_valid && !out_ready;
      stall_data  = out_data;
      stall_delta = out_delta;
    end
  end

  initial begin
    // 1. Reset for two cycles with dout held at zero.
    reset = 1'b1; dout_in = 8'h00; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_valid", int'(out_valid), 0);
    check("rst_count", int'(count), 0);
    check("rst_overflow", int'(overflow), 0);

    // 2. Single change 0 -> 0x05, consumed immediately.
    out_ready = 1'b1; dout_in = 8'h05; expect_ev(8'h05, 8'h05);
    tick();
    check("single_valid", int'(out_valid), 1);
    check("single_count", int'(count), 1);
    tick();
    check("single_drained", int'(count), 0);

    // Return to zero so the next burst measures from prev=0 (0x00-0x05 = 0xFB).
    dout_in = 8'h00; expect_ev(8'h00, 8'hFB);
    tick(); tick();
    check("zero_drained", int'(count), 0);

    // 3. Stalled burst of five changes into a 4-deep FIFO; the fifth is dropped.
    out_ready = 1'b0;
    dout_in = 8'h01; expect_ev(8'h01, 8'h01); tick();
    dout_in = 8'h02; expect_ev(8'h02, 8'h01); tick();
    dout_in = 8'h03; expect_ev(8'h03, 8'h01); tick();
    dout_in = 8'h04; expect_ev(8'h04, 8'h01); tick();
    check("fill_count", int'(count), 4);
    check("fill_no_overflow", int'(overflow), 0);
    dout_in = 8'h05; tick();
    check("drop_count", int'(count), 4);
    check("drop_overflow", int'(overflow), 1);

    // 4. Full FIFO with push and pop in the same cycle (0x06-0x05 = 0x01).
    out_ready = 1'b1; dout_in = 8'h06; expect_ev(8'h06, 8'h01);
    tick();
    check("fullpp_count", int'(count), 4);
    check("fullpp_overflow", int'(overflow), 1);
    tick(); tick(); tick(); tick();
    check("drain_count", int'(count), 0);
    check("drain_valid", int'(out_valid), 0);
    check("sticky_overflow", int'(overflow), 1);

    // 5. Wrapping subtraction: 0xFE-0x06 = 0xF8, then 0x02-0xFE = 0x04.
    dout_in = 8'hFE; expect_ev(8'hFE, 8'hF8); tick();
    dout_in = 8'h02; expect_ev(8'h02, 8'h04); tick();
    tick();
    check("wrap_drained", int'(count), 0);

    // 6. Reset with three entries queued discards them all.
    out_ready = 1'b0;
    dout_in = 8'h10; tick();
    dout_in = 8'h11; tick();
    dout_in = 8'h12; tick();
    check("pending_count", int'(count), 3);
    reset = 1'b1; dout_in = 8'h00; exp_q.delete();
    tick();
    reset = 1'b0;
    check("midrst_count", int'(count), 0);
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_overflow", int'(overflow), 0);
    out_ready = 1'b1; dout_in = 8'h07; expect_ev(8'h07, 8'h07);
    tick();
    check("post_rst_count", int'(count), 1);
    tick();
    check("post_rst_drained", int'(count), 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
